// File: rtl/tone_decay_env_if.sv
// Signal bundle between the tone envelope stage and its driver/consumer.
interface tone_decay_env_if #(
  parameter int AMP_WIDTH = 8
);
  logic                 TONE_IN;
  logic                 TRIG;
  logic                 ENABLE;
  logic [AMP_WIDTH-1:0] AUDIO_OUT;
  logic                 ACTIVE;

  modport master (
    output TONE_IN, TRIG, ENABLE,
    input  AUDIO_OUT, ACTIVE
  );

  modport slave (
    input  TONE_IN, TRIG, ENABLE,
    output AUDIO_OUT, ACTIVE
  );
endinterface

// File: rtl/tone_decay_env.sv
// Trigger-loaded, linearly decaying envelope gated by the 555 astable tone.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | envelope at 0, waiting for a TRIG rising edge
//   S_DECAY | envelope loaded, stepping down once per prescaler wrap
module tone_decay_env #(
  parameter int AMP_WIDTH         = 8,
  parameter int ATTACK_LEVEL      = 255,
  parameter int DECAY_STEP        = 1,
  parameter int DECAY_STEP_COUNTS = 1000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  tone_decay_env_if.slave   bus
);

  localparam int PW = (DECAY_STEP_COUNTS > 1) ? $clog2(DECAY_STEP_COUNTS) : 1;
  localparam logic [PW-1:0]        PRE_LAST = PW'(DECAY_STEP_COUNTS - 1);
  localparam logic [AMP_WIDTH-1:0] ATTACK   = AMP_WIDTH'(ATTACK_LEVEL);
  localparam logic [AMP_WIDTH-1:0] STEP     = AMP_WIDTH'(DECAY_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DECAY = 2'd1
  } state_t;

  state_t               state_q, state_d;
  logic [AMP_WIDTH-1:0] env_q, env_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic                 trig_q;
  logic                 tone_q;
  logic [AMP_WIDTH-1:0] audio_q;
  logic                 active_q;
  logic                 trig_edge;

  // A held-high TRIG while disabled leaves trig_q high, so re-enabling does not fire.
  assign trig_edge = bus.TRIG & ~trig_q & bus.ENABLE;

  // Next-state: disable clears, retrigger beats a coincident decay tick.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    pre_d   = pre_q;
    if (!bus.ENABLE) begin
      state_d = S_IDLE;
      env_d   = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig_edge) begin
            state_d = S_DECAY;
            env_d   = ATTACK;
            pre_d   = '0;
          end
        end
        S_DECAY: begin
          if (trig_edge) begin
            env_d = ATTACK;
            pre_d = '0;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (env_q > STEP) begin
              env_d = env_q - STEP;
            end else begin
              env_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          env_d   = '0;
          pre_d   = '0;
        end
      endcase
    end
  end

  // State, envelope and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      env_q    <= '0;
      pre_q    <= '0;
      trig_q   <= 1'b0;
      tone_q   <= 1'b0;
      audio_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      pre_q    <= pre_d;
      trig_q   <= bus.TRIG;
      tone_q   <= bus.TONE_IN;
      audio_q  <= tone_q ? env_q : '0;
      active_q <= (state_d == S_DECAY);
    end
  end

  assign bus.AUDIO_OUT = audio_q;
  assign bus.ACTIVE    = active_q;

endmodule
